// File: rtl/dcnt_pkg.sv
// Shared types and helpers for the parametrised delay counter tile.
package dcnt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } dcnt_state_e;

  // Prescaler phase width; at least one bit so DIV=1 still has a legal vector.
  function automatic int presc_width(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/dcnt_prescaler.sv
// Divide-by-DIV enable generator: tick_o fires on the last phase while en_i is high.
module dcnt_prescaler
  import dcnt_pkg::*;
#(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic clr,
  input  logic en_i,
  input  logic sclr_i,
  output logic tick_o
);

  localparam int PW = presc_width(DIV);
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  logic [PW-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (sclr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tick_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/delay_counter_param.sv
// Loadable up/down delay counter with run/hold, one-shot or auto-reload mode,
// prescaled stepping and a registered one-clock terminal-count pulse.
//   state   | meaning
//   IDLE    | out of reset, never loaded; s_s ignored
//   RUN     | counting on prescaler ticks
//   HOLD    | loaded, count and prescaler frozen
//   DONE    | one-shot expired; waits for load
module delay_counter_param
  import dcnt_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIV   = 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             l,
  input  logic             s_s,
  input  logic             up_dn,
  input  logic             rld,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] c,
  output logic             tc,
  output logic             done,
  output logic             busy
);

  dcnt_state_e      state_q, state_d;
  logic [WIDTH-1:0] c_q, c_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             dir_q, dir_d;
  logic             mode_q, mode_d;
  logic             tc_q, tc_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             presc_en;
  logic             tick;
  logic [WIDTH-1:0] term;

  // The prescaler only advances on edges that stay in RUN and are not loads.
  assign presc_en = (state_q == ST_RUN) && s_s && !l;

  dcnt_prescaler #(.DIV(DIV)) u_presc (
    .clk    (clk),
    .clr    (clr),
    .en_i   (presc_en),
    .sclr_i (l),
    .tick_o (tick)
  );

  assign term = dir_q ? r_q : '0;

  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    r_d     = r_q;
    dir_d   = dir_q;
    mode_d  = mode_q;
    tc_d    = 1'b0;
    done_d  = done_q;
    if (l) begin
      r_d     = d;
      dir_d   = up_dn;
      mode_d  = rld;
      c_d     = up_dn ? '0 : d;
      done_d  = 1'b0;
      state_d = s_s ? ST_RUN : ST_HOLD;
    end else begin
      unique case (state_q)
        ST_IDLE: ;
        ST_DONE: ;
        ST_HOLD: if (s_s) state_d = ST_RUN;
        ST_RUN: begin
          if (!s_s) begin
            state_d = ST_HOLD;
          end else if (tick) begin
            if (c_q != term) begin
              c_d = dir_q ? c_q + 1'b1 : c_q - 1'b1;
            end else begin
              tc_d = 1'b1;
              if (mode_q) begin
                c_d = dir_q ? '0 : r_q;
              end else begin
                done_d  = 1'b1;
                state_d = ST_DONE;
              end
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    busy_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= ST_IDLE;
      c_q     <= '0;
      r_q     <= '0;
      dir_q   <= 1'b0;
      mode_q  <= 1'b0;
      tc_q    <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      r_q     <= r_d;
      dir_q   <= dir_d;
      mode_q  <= mode_d;
      tc_q    <= tc_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign c    = c_q;
  assign tc   = tc_q;
  assign done = done_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_delay_counter_param.sv
// Bench for delay_counter_param: three instances (8b/DIV1, 8b/DIV4, 16b/DIV1) share
// stimulus and are checked each cycle against a rule-level model plus literal pins.
module tb_delay_counter_param;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        l = 1'b0, s_s = 1'b0, up_dn = 1'b0, rld = 1'b0;
  logic [15:0] d = 16'h0;

  logic [7:0]  c_a, c_b;
  logic [15:0] c_c;
  logic        tc_a, done_a, busy_a;
  logic        tc_b, done_b, busy_b;
  logic        tc_c, done_c, busy_c;

  always #9 clk = ~clk;

  delay_counter_param #(.WIDTH(8), .DIV(1)) dut_a (
    .clk(clk), .clr(clr), .l(l), .s_s(s_s), .up_dn(up_dn), .rld(rld), .d(d[7:0]),
    .c(c_a), .tc(tc_a), .done(done_a), .busy(busy_a));

  delay_counter_param #(.WIDTH(8), .DIV(4)) dut_b (
    .clk(clk), .clr(clr), .l(l), .s_s(s_s), .up_dn(up_dn), .rld(rld), .d(d[7:0]),
    .c(c_b), .tc(tc_b), .done(done_b), .busy(busy_b));

  delay_counter_param #(.WIDTH(16), .DIV(1)) dut_c (
    .clk(clk), .clr(clr), .l(l), .s_s(s_s), .up_dn(up_dn), .rld(rld), .d(d),
    .c(c_c), .tc(tc_c), .done(done_c), .busy(busy_c));

  localparam int M_IDLE = 0, M_RUN = 1, M_HOLD = 2, M_DONE = 3;

  typedef struct {
    int c; int r; int up; int rl; int pre; int st; int tc; int done;
  } mdl_t;

  mdl_t m [3];
  int   mdiv  [3] = '{1, 4, 1};
  int   mmask [3] = '{255, 255, 65535};

  int  n_chk = 0, n_fail = 0;
  bit  chk_en = 1'b0;

  function automatic mdl_t mreset();
    mdl_t z;
    z.c = 0; z.r = 0; z.up = 0; z.rl = 0; z.pre = 0; z.st = M_IDLE; z.tc = 0; z.done = 0;
    return z;
  endfunction

  // One clock of the counter described as plain rules on integers.
  function automatic mdl_t step(mdl_t s, int div, int mask, bit li, bit ssi, bit upi, bit rli, int di);
    mdl_t n = s;
    int term;
    n.tc = 0;
    if (li) begin
      n.r = di & mask; n.up = upi; n.rl = rli;
      n.c = upi ? 0 : (di & mask);
      n.pre = 0; n.done = 0;
      n.st = ssi ? M_RUN : M_HOLD;
    end else if (s.st == M_HOLD && ssi) begin
      n.st = M_RUN;
    end else if (s.st == M_RUN && !ssi) begin
      n.st = M_HOLD;
    end else if (s.st == M_RUN) begin
      n.pre = (s.pre + 1) % div;
      if (n.pre == 0) begin
        term = s.up ? s.r : 0;
        if (s.c != term) begin
          n.c = s.up ? s.c + 1 : s.c - 1;
        end else begin
          n.tc = 1;
          if (s.rl) n.c = s.up ? 0 : s.r;
          else begin
            n.done = 1;
            n.st = M_DONE;
          end
        end
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge clr) begin
    if (!clr) begin
      for (int i = 0; i < 3; i++) m[i] = mreset();
    end else begin
      for (int i = 0; i < 3; i++)
        m[i] = step(m[i], mdiv[i], mmask[i], l, s_s, up_dn, rld, int'(d));
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic cmp(input int i, input logic [15:0] cv, input logic tv, input logic dv, input logic bv);
    check($sformatf("model c[%0d]", i), {16'h0, cv}, m[i].c);
    check($sformatf("model tc[%0d]", i), {31'h0, tv}, m[i].tc);
    check($sformatf("model done[%0d]", i), {31'h0, dv}, m[i].done);
    check($sformatf("model busy[%0d]", i), {31'h0, bv}, (m[i].st == M_RUN) ? 1 : 0);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp(0, {8'h00, c_a}, tc_a, done_a, busy_a);
      cmp(1, {8'h00, c_b}, tc_b, done_b, busy_b);
      cmp(2, c_c, tc_c, done_c, busy_c);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input logic [15:0] dv, input bit up, input bit rl, input bit ss);
    l = 1'b1; d = dv; up_dn = up; rld = rl; s_s = ss;
    cyc(1);
    l = 1'b0;
  endtask

  int tcn;

  initial begin
    #2 clr = 1'b0;
    cyc(1);
    clr = 1'b1;
    chk_en = 1'b1;
    check("reset c", {24'h0, c_a}, 0);
    check("reset busy", {31'h0, busy_a}, 0);
    cyc(2);
    check("idle ignores s_s", {24'h0, c_a}, 0);

    // async clear mid-count
    load(16'h0045, 1'b0, 1'b0, 1'b1);
    cyc(5);
    check("pre-clear c", {24'h0, c_a}, 32'h40);
    #3 clr = 1'b0;
    #1;
    check("async clr c", {24'h0, c_a}, 0);
    check("async clr tc", {31'h0, tc_a}, 0);
    check("async clr done", {31'h0, done_a}, 0);
    check("async clr busy", {31'h0, busy_a}, 0);
    #2 clr = 1'b1;
    cyc(1);

    // down one-shot from 5
    load(16'h0005, 1'b0, 1'b0, 1'b1);
    check("os c0", {24'h0, c_a}, 5);
    for (int k = 1; k <= 5; k++) begin
      cyc(1);
      check("os c", {24'h0, c_a}, 5 - k);
      check("os tc early", {31'h0, tc_a}, 0);
    end
    cyc(1);
    check("os tc", {31'h0, tc_a}, 1);
    check("os done", {31'h0, done_a}, 1);
    cyc(1);
    check("os tc width", {31'h0, tc_a}, 0);
    for (int k = 0; k < 4; k++) begin
      s_s = ~s_s;
      cyc(1);
    end
    check("done hold c", {24'h0, c_a}, 0);
    check("done hold", {31'h0, done_a}, 1);
    check("done busy", {31'h0, busy_a}, 0);

    // up reload, DIV=4 instance
    load(16'h0003, 1'b1, 1'b1, 1'b1);
    tcn = 0;
    for (int k = 1; k <= 32; k++) begin
      cyc(1);
      if (tc_b) tcn++;
      if (k % 4 == 0 && k <= 16)
        check("div4 c", {24'h0, c_b}, (k / 4) % 4);
      if (k == 16) check("div4 tc", {31'h0, tc_b}, 1);
    end
    check("div4 tc count", tcn, 2);

    // hold at 0x80
    load(16'h0085, 1'b0, 1'b0, 1'b1);
    cyc(5);
    check("hold entry c", {24'h0, c_a}, 32'h80);
    s_s = 1'b0;
    cyc(10);
    check("hold c", {24'h0, c_a}, 32'h80);
    check("hold busy", {31'h0, busy_a}, 0);
    s_s = 1'b1;
    cyc(1);
    check("resume c", {24'h0, c_a}, 32'h80);
    check("resume busy", {31'h0, busy_a}, 1);
    cyc(1);
    check("resume step", {24'h0, c_a}, 32'h7F);

    // load collides with reload terminal
    load(16'h0002, 1'b0, 1'b1, 1'b1);
    cyc(2);
    check("pre-collide c", {24'h0, c_a}, 0);
    l = 1'b1; d = 16'h00F0;
    cyc(1);
    l = 1'b0;
    check("collide c", {24'h0, c_a}, 32'hF0);
    check("collide tc", {31'h0, tc_a}, 0);
    cyc(1);
    check("collide tc next", {31'h0, tc_a}, 0);
    check("collide step", {24'h0, c_a}, 32'hEF);

    // zero reload down: tc every cycle
    load(16'h0000, 1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 5; k++) begin
      cyc(1);
      check("r0 tc", {31'h0, tc_a}, 1);
    end

    // 16-bit up to full scale, one-shot
    load(16'hFFFF, 1'b1, 1'b0, 1'b1);
    tcn = 0;
    for (int k = 0; k < 65540; k++) begin
      cyc(1);
      if (tc_c) tcn++;
    end
    check("w16 c", {16'h0, c_c}, 32'hFFFF);
    check("w16 done", {31'h0, done_c}, 1);
    check("w16 tc count", tcn, 1);

    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      l = ($urandom_range(0, 15) == 0);
      s_s = ($urandom_range(0, 7) != 0);
      up_dn = $urandom_range(0, 1);
      rld = $urandom_range(0, 1);
      d = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 24));
      if ($urandom_range(0, 499) == 0) begin
        #3 clr = 1'b0;
        #2 clr = 1'b1;
      end
      cyc(1);
    end

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
